// File: rtl/cp_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : cp_imem_loader
//  Brief    : CP instruction memory with a one-cycle registered fetch port and
//             a byte-stream program loader that holds the CP in reset while
//             the program store is being filled.
//  Revision : 1.0 - initial release
// ============================================================================
module cp_imem_loader #(
   parameter int INS_WIDTH  = 24,
   parameter int ADDR_WIDTH = 10,
   parameter int DEPTH      = 1024
) (
   input  logic                  iClk,
   input  logic                  iReset_n,
   input  logic                  iLoad_Start,
   input  logic [ADDR_WIDTH:0]   iLoad_Length,
   input  logic [7:0]            iLoad_Byte,
   input  logic                  iLoad_Valid,
   output logic                  oLoad_Ready,
   output logic                  oLoad_Done,
   output logic                  oCore_Reset,
   input  logic [ADDR_WIDTH-1:0] iIF_IMEM_Addr,
   output logic [INS_WIDTH-1:0]  oIMEM_IF_Instruction
);

   // Length field is one bit wider than the address so that DEPTH fits.
   localparam int LW = ADDR_WIDTH + 1;
   localparam int AW = INS_WIDTH - 8;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_RUN  = 2'd2;

   localparam logic [LW-1:0] C_DEPTH = LW'(DEPTH);
   localparam logic [LW-1:0] C_ONE   = LW'(1);

   logic [1:0]            state_q, state_d;
   logic [LW-1:0]         len_q, len_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [1:0]            bcnt_q, bcnt_d;
   logic [AW-1:0]         asm_q, asm_d;
   logic                  core_reset_q, core_reset_d;
   logic                  done_q, done_d;
   logic [INS_WIDTH-1:0]  rd_q;

   logic [INS_WIDTH-1:0]  mem [DEPTH];

   logic                  w_accept;
   logic                  w_word_done;
   logic                  w_last_word;
   logic                  w_start_load;
   logic [LW-1:0]         w_len_clamped;

   // A byte is only taken while loading and out of reset; the third byte of
   // a word completes it, and the word at index length-1 ends the load.
   assign w_accept      = iReset_n && (state_q == S_LOAD) && iLoad_Valid;
   assign w_word_done   = w_accept && (bcnt_q == 2'd2);
   assign w_last_word   = w_word_done && ({1'b0, addr_q} == (len_q - C_ONE));
   assign w_start_load  = (state_q != S_LOAD) && iLoad_Start && (iLoad_Length != '0);
   assign w_len_clamped = (iLoad_Length > C_DEPTH) ? C_DEPTH : iLoad_Length;

   // State register and registered control outputs.
   always_ff @(posedge iClk) begin
      if (!iReset_n) begin
         state_q      <= S_IDLE;
         core_reset_q <= 1'b1;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         core_reset_q <= core_reset_d;
         done_q       <= done_d;
      end
   end

   // Next-state decode: starts are honoured only outside LOAD.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_RUN: begin
            if (iLoad_Start) begin
               state_d = (iLoad_Length == '0) ? S_RUN : S_LOAD;
            end
         end
         S_LOAD: begin
            if (w_last_word) begin
               state_d = S_RUN;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output decode: core reset and done follow the state being entered.
   always_comb begin
      oLoad_Ready  = (state_q == S_LOAD);
      core_reset_d = (state_d != S_RUN);
      done_d       = (state_d == S_RUN);
   end

   // Loader datapath next-state: length latch, word address, byte assembly.
   always_comb begin
      len_d  = len_q;
      addr_d = addr_q;
      bcnt_d = bcnt_q;
      asm_d  = asm_q;
      if (w_start_load) begin
         len_d  = w_len_clamped;
         addr_d = '0;
         bcnt_d = 2'd0;
      end else if (w_accept) begin
         case (bcnt_q)
            2'd0: begin
               asm_d[AW-1:8] = iLoad_Byte;
               bcnt_d        = 2'd1;
            end
            2'd1: begin
               asm_d[7:0] = iLoad_Byte;
               bcnt_d     = 2'd2;
            end
            default: begin
               addr_d = addr_q + ADDR_WIDTH'(1);
               bcnt_d = 2'd0;
            end
         endcase
      end
   end

   // Loader datapath registers; a reset discards any partial word.
   always_ff @(posedge iClk) begin
      if (!iReset_n) begin
         len_q  <= '0;
         addr_q <= '0;
         bcnt_q <= 2'd0;
         asm_q  <= '0;
      end else begin
         len_q  <= len_d;
         addr_q <= addr_d;
         bcnt_q <= bcnt_d;
         asm_q  <= asm_d;
      end
   end

   // Program store write: the completed word lands on the third byte's edge.
   always_ff @(posedge iClk) begin
      if (w_word_done) begin
         mem[addr_q] <= {asm_q, iLoad_Byte};
      end
   end

   // Registered fetch port, read-first; forced to NOP while the core is held.
   always_ff @(posedge iClk) begin
      if (!iReset_n) begin
         rd_q <= '0;
      end else if (state_d == S_RUN) begin
         rd_q <= mem[iIF_IMEM_Addr];
      end else begin
         rd_q <= '0;
      end
   end

   assign oLoad_Done           = done_q;
   assign oCore_Reset          = core_reset_q;
   assign oIMEM_IF_Instruction = rd_q;

endmodule
`default_nettype wire

// File: tb/tb_cp_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cp_imem_loader
//  Brief    : Self-checking bench for cp_imem_loader with a fetch scoreboard
//             and a word-level memory model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cp_imem_loader;

   localparam int AW    = 10;
   localparam int LW    = AW + 1;
   localparam int DEPTH = 1024;
   localparam int IW    = 24;

   logic          r_clk = 1'b0;
   logic          r_rst_n;
   logic          r_start;
   logic [LW-1:0] r_len;
   logic [7:0]    r_byte;
   logic          r_valid;
   logic [AW-1:0] r_addr;
   logic          w_ready;
   logic          w_done;
   logic          w_core_rst;
   logic [IW-1:0] w_instr;

   always #5 r_clk = ~r_clk;

   cp_imem_loader #(
      .INS_WIDTH  (IW),
      .ADDR_WIDTH (AW),
      .DEPTH      (DEPTH)
   ) dut (
      .iClk                 (r_clk),
      .iReset_n             (r_rst_n),
      .iLoad_Start          (r_start),
      .iLoad_Length         (r_len),
      .iLoad_Byte           (r_byte),
      .iLoad_Valid          (r_valid),
      .oLoad_Ready          (w_ready),
      .oLoad_Done           (w_done),
      .oCore_Reset          (w_core_rst),
      .iIF_IMEM_Addr        (r_addr),
      .oIMEM_IF_Instruction (w_instr)
   );

   int          checks   = 0;
   int          failures = 0;
   int unsigned cyc      = 0;
   int          hi_known = -1;

   typedef struct {
      int unsigned cyc;
      logic [IW-1:0] val;
   } exp_t;

   exp_t          sb[$];
   logic [IW-1:0] mem_model [DEPTH];
   logic [7:0]    bq[$];

   always @(posedge r_clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chk_flags(input string tag, input logic rdy, input logic dn, input logic crst);
      chk({tag, ".ready"},      {31'd0, w_ready},    {31'd0, rdy});
      chk({tag, ".done"},       {31'd0, w_done},     {31'd0, dn});
      chk({tag, ".core_reset"}, {31'd0, w_core_rst}, {31'd0, crst});
   endtask

   // Expected fetch result, due after the next active edge.
   task automatic expect_rd(input logic [IW-1:0] v);
      exp_t e;
      e.cyc = cyc + 1;
      e.val = v;
      sb.push_back(e);
   endtask

   // Scoreboard monitor: compares the fetch register against queued results.
   always @(negedge r_clk) begin : mon
      exp_t e;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         e = sb.pop_front();
         if (e.cyc == cyc) begin
            chk("fetch_data", {8'd0, w_instr}, {8'd0, e.val});
         end else begin
            checks++;
            failures++;
            $display("FAIL fetch_missed: due cycle %0d, now %0d", e.cyc, cyc);
         end
      end
   end

   function automatic logic [AW-1:0] rand_known();
      return AW'($urandom_range(hi_known));
   endfunction

   task automatic fetch(input int n, input int fixed_addr);
      for (int i = 0; i < n; i++) begin
         r_addr = (fixed_addr < 0) ? rand_known() : AW'(fixed_addr);
         expect_rd(mem_model[r_addr]);
         @(negedge r_clk);
      end
   endtask

   // Runs one load with the bytes in bq. mode: 0 back-to-back, 1 toggle, 2 random stalls.
   task automatic do_load(input int len_field, input int mode, input bit byte_with_start);
      int nw;
      int nb;
      int ns;
      nw = (len_field > DEPTH) ? DEPTH : len_field;
      nb = bq.size();
      r_start = 1'b1;
      r_len   = LW'(len_field);
      r_valid = byte_with_start;
      r_byte  = 8'hFF;
      r_addr  = AW'($urandom);
      @(negedge r_clk);
      r_start = 1'b0;
      for (int i = 0; i < nb; i++) begin
         chk_flags("load", 1'b1, 1'b0, 1'b1);
         ns = (mode == 1) ? 1 : (mode == 2) ? $urandom_range(2) : 0;
         repeat (ns) begin
            r_valid = 1'b0;
            r_byte  = 8'($urandom);
            r_start = ($urandom_range(3) == 0);
            r_len   = '0;
            r_addr  = AW'($urandom);
            expect_rd('0);
            @(negedge r_clk);
            r_start = 1'b0;
            chk_flags("stall", 1'b1, 1'b0, 1'b1);
         end
         r_valid = 1'b1;
         r_byte  = bq[i];
         r_addr  = AW'($urandom);
         if (i != nb - 1) expect_rd('0);
         if (i % 3 == 2) mem_model[i / 3] = {bq[i - 2], bq[i - 1], bq[i]};
         @(negedge r_clk);
      end
      r_valid = 1'b0;
      r_byte  = 8'h00;
      chk_flags("run_entry", 1'b0, 1'b1, 1'b0);
      if (nw - 1 > hi_known) hi_known = nw - 1;
      bq.delete();
   endtask

   initial begin : watchdog
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      r_rst_n = 1'b0;
      r_start = 1'b0;
      r_len   = '0;
      r_byte  = 8'h00;
      r_valid = 1'b0;
      r_addr  = '0;

      // Reset values
      repeat (3) @(negedge r_clk);
      chk_flags("reset", 1'b0, 1'b0, 1'b1);
      chk("reset.instr", {8'd0, w_instr}, 32'd0);
      r_rst_n = 1'b1;
      @(negedge r_clk);
      chk_flags("idle", 1'b0, 1'b0, 1'b1);

      // Basic load and fetch
      bq = '{8'h12, 8'h34, 8'h56, 8'hAB, 8'hCD, 8'hEF};
      do_load(2, 0, 1'b0);
      fetch(1, 1);
      fetch(1, 0);

      // Throttled: same load with valid toggling, then a random-stall load
      bq = '{8'h12, 8'h34, 8'h56, 8'hAB, 8'hCD, 8'hEF};
      do_load(2, 1, 1'b0);
      fetch(1, 0);
      fetch(1, 1);
      for (int i = 0; i < 15; i++) bq.push_back(8'($urandom));
      do_load(5, 2, 1'b0);
      fetch(8, -1);

      // Reset mid-load: one full word plus one byte, then reset
      r_start = 1'b1;
      r_len   = LW'(3);
      @(negedge r_clk);
      r_start = 1'b0;
      foreach (bq[i]) bq.delete();
      bq = '{8'h11, 8'h11, 8'h11, 8'h22};
      for (int i = 0; i < 4; i++) begin
         r_valid = 1'b1;
         r_byte  = bq[i];
         @(negedge r_clk);
      end
      bq.delete();
      mem_model[0] = 24'h111111;
      r_valid = 1'b0;
      r_rst_n = 1'b0;
      repeat (2) @(negedge r_clk);
      chk_flags("midreset", 1'b0, 1'b0, 1'b1);
      chk("midreset.instr", {8'd0, w_instr}, 32'd0);
      r_rst_n = 1'b1;
      @(negedge r_clk);
      chk_flags("midreset_idle", 1'b0, 1'b0, 1'b1);
      r_start = 1'b1;
      r_len   = '0;
      @(negedge r_clk);
      r_start = 1'b0;
      chk_flags("len0_run", 1'b0, 1'b1, 1'b0);
      fetch(1, 0);
      fetch(4, -1);

      // Length 0 while running keeps the core running
      r_start = 1'b1;
      r_len   = '0;
      r_addr  = 10'd1;
      expect_rd(mem_model[1]);
      @(negedge r_clk);
      r_start = 1'b0;
      chk_flags("run_len0", 1'b0, 1'b1, 1'b0);

      // Reload from RUN, with a byte presented alongside the start
      bq = '{8'h00, 8'h00, 8'h07};
      do_load(1, 0, 1'b1);
      fetch(1, 0);
      fetch(4, -1);

      // Boundary: length above DEPTH is clamped
      for (int i = 0; i < 3 * DEPTH; i++) bq.push_back(8'($urandom));
      do_load(DEPTH + 1, 0, 1'b0);
      fetch(1, DEPTH - 1);
      fetch(1, 0);
      fetch(16, -1);

      repeat (3) @(negedge r_clk);
      chk("sb_drain", sb.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
